ddr3_arbiter: RTL and testbench

- Single-clock scheduler between the UART-fed write FIFO and the HDMI-side read FIFO, sharing one DDR3 controller user port (MIG app interface, 128-bit data, 4:1 mode).
- Grants whole bursts to the write path (triggered by `wr_trig`) or the read path (triggered by `rd_trig`). Issues the app-interface commands and strobes the FIFO enables.
- Keeps independent frame-linear write and read addresses, each wrapping at one frame.
- The data buses (`wfifo_rd_data` to `app_wdf_data`, `app_rd_data` to `rfifo_wr_data`) are wired outside this block.

---
 rtl/ddr3_arbiter_if.sv | 34 +++
 rtl/ddr3_arbiter.sv | 97 +++++++++
 tb/tb_ddr3_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_arbiter_if.sv
// Bundle between the DDR3 burst arbiter, the MIG user port and the two frame FIFOs.
// The arbiter uses the master modport; the controller/FIFO side uses slave.
interface ddr3_arbiter_if #(
  parameter int ADDR_W = 28
);
  logic              init_calib_complete;
  logic              wr_trig;
  logic              rd_trig;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              wfifo_rd_en;
  logic              rfifo_wr_en;
  logic              wr_frame_end;
  logic              rd_frame_end;
  logic              busy;

  modport master (
    input  init_calib_complete, wr_trig, rd_trig, app_rdy, app_wdf_rdy, app_rd_data_valid,
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, wfifo_rd_en,
           rfifo_wr_en, wr_frame_end, rd_frame_end, busy
  );

  modport slave (
    output init_calib_complete, wr_trig, rd_trig, app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, wfifo_rd_en,
           rfifo_wr_en, wr_frame_end, rd_frame_end, busy
  );
endinterface

// File: rtl/ddr3_arbiter.sv
// Burst scheduler sharing one MIG app port between the write FIFO and the read FIFO,
// with independent frame-linear write/read addresses that wrap every frame.
module ddr3_arbiter #(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 115200,
  parameter int ADDR_STEP   = 8,
  parameter int ADDR_W      = 28
) (
  input  logic sclk,
  input  logic s_rst,
  ddr3_arbiter_if.master bus
);
  localparam int                CW   = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]     BL   = CW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] WRAP = ADDR_W'(FRAME_BEATS * ADDR_STEP);

  typedef enum logic [1:0] {IDLE, ARB, WR, RD} state_t;

  state_t            state;
  logic              last_wr;
  logic [CW-1:0]     cmd_cnt, ret_cnt, ret_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_inc, rd_inc;
  logic              wr_fe, rd_fe;
  logic              cmd_open, wr_fire, rd_req, rd_acc, wr_wrap, rd_wrap;

  assign cmd_open = cmd_cnt < BL;
  assign wr_fire  = (state == WR) && cmd_open && bus.app_rdy && bus.app_wdf_rdy;
  assign rd_req   = (state == RD) && cmd_open;
  assign rd_acc   = rd_req && bus.app_rdy;
  assign ret_nxt  = ret_cnt + CW'(bus.app_rd_data_valid);
  assign wr_inc   = wr_addr + STEP;
  assign rd_inc   = rd_addr + STEP;
  assign wr_wrap  = (wr_inc == WRAP);
  assign rd_wrap  = (rd_inc == WRAP);

  assign bus.app_en       = wr_fire || rd_req;
  assign bus.app_cmd      = (state == RD) ? 3'b001 : 3'b000;
  assign bus.app_addr     = (state == WR) ? wr_addr : (state == RD) ? rd_addr : '0;
  assign bus.app_wdf_wren = wr_fire;
  assign bus.app_wdf_end  = wr_fire;
  assign bus.wfifo_rd_en  = wr_fire;
  assign bus.rfifo_wr_en  = bus.app_rd_data_valid;
  assign bus.wr_frame_end = wr_fe;
  assign bus.rd_frame_end = rd_fe;
  assign bus.busy         = (state != IDLE);

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state   <= IDLE;
      last_wr <= 1'b1;
      cmd_cnt <= '0;
      ret_cnt <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      wr_fe   <= 1'b0;
      rd_fe   <= 1'b0;
    end else begin
      wr_fe <= 1'b0;
      rd_fe <= 1'b0;
      if (wr_fire) begin
        cmd_cnt <= cmd_cnt + 1'b1;
        wr_addr <= wr_wrap ? '0 : wr_inc;
        wr_fe   <= wr_wrap;
      end
      if (rd_acc) begin
        cmd_cnt <= cmd_cnt + 1'b1;
        rd_addr <= rd_wrap ? '0 : rd_inc;
        rd_fe   <= rd_wrap;
      end
      if (state == RD && bus.app_rd_data_valid) ret_cnt <= ret_nxt;
      case (state)
        IDLE: if (bus.init_calib_complete) state <= ARB;
        ARB: begin
          // Contested grants go to whichever path did not win last time.
          if (!bus.init_calib_complete) begin
            state <= IDLE;
          end else if (bus.wr_trig && (!bus.rd_trig || !last_wr)) begin
            state   <= WR;
            last_wr <= 1'b1;
            cmd_cnt <= '0;
            ret_cnt <= '0;
          end else if (bus.rd_trig) begin
            state   <= RD;
            last_wr <= 1'b0;
            cmd_cnt <= '0;
            ret_cnt <= '0;
          end
        end
        WR: if (cmd_cnt == BL) state <= ARB;
        // A beat landing this cycle counts toward completion.
        RD: if (cmd_cnt == BL && ret_nxt == BL) state <= ARB;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_arbiter.sv
// Randomized bench for ddr3_arbiter: a MIG-like responder plus a frame-address and
// grant-order model derived from the burst rules.
module tb_ddr3_arbiter;
  localparam int BL = 16, FB = 32, STEP = 8, AW = 28;

  typedef struct {
    int       cyc;
    logic [2:0] cmd;
    int       addr;
  } cmd_t;

  logic sclk = 1'b0;
  logic s_rst = 1'b1;
  always #5 sclk = ~sclk;

  ddr3_arbiter_if #(.ADDR_W(AW)) bus();

  ddr3_arbiter #(.BURST_LEN(BL), .FRAME_BEATS(FB), .ADDR_STEP(STEP), .ADDR_W(AW)) dut (
    .sclk(sclk), .s_rst(s_rst), .bus(bus.master)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  cmd_t cmd_q[$];
  int ret_q[$];
  int lat = 20, last_due = 0;
  bit rand_rdy = 0;
  int wfifo_n = 0, rfifo_n = 0, wfe_n = 0, rfe_n = 0, wfe_cyc = 0, last_ret_cyc = 0;
  int en_n = 0, busy_n = 0, bad_n = 0;
  bit prev_rd_wait = 0;
  logic [AW-1:0] prev_addr;
  // reference model: frame position in beats, frame wraps seen, last grant
  int m_wr_beat = 0, m_rd_beat = 0, m_wfe = 0, m_rfe = 0;
  bit m_last_wr = 1;
  int g_n0, g_wf0;

  always @(posedge sclk) cyc <= cyc + 1;

  // Observer: logs accepted commands, counts strobes, flags handshake-rule violations.
  always @(negedge sclk) begin
    if (s_rst) begin
      prev_rd_wait = 0;
    end else begin
      if (bus.app_en) en_n++;
      if (bus.busy) busy_n++;
      if (bus.wfifo_rd_en) wfifo_n++;
      if (bus.rfifo_wr_en) begin rfifo_n++; last_ret_cyc = cyc; end
      if (bus.wr_frame_end) begin wfe_n++; wfe_cyc = cyc; end
      if (bus.rd_frame_end) rfe_n++;
      if (bus.rfifo_wr_en !== bus.app_rd_data_valid) bad_n++;
      if (bus.app_cmd == 3'b000) begin
        if (bus.app_wdf_wren !== bus.app_en || bus.app_wdf_end !== bus.app_en ||
            bus.wfifo_rd_en !== bus.app_en) bad_n++;
        if (bus.app_en && !(bus.app_rdy && bus.app_wdf_rdy)) bad_n++;
      end else if (bus.app_cmd == 3'b001) begin
        if (bus.app_wdf_wren || bus.wfifo_rd_en) bad_n++;
      end else bad_n++;
      if (prev_rd_wait && !(bus.app_en && bus.app_cmd == 3'b001 && bus.app_addr == prev_addr)) bad_n++;
      prev_rd_wait = bus.app_en && bus.app_cmd == 3'b001 && !bus.app_rdy;
      prev_addr = bus.app_addr;
      if (bus.app_en && bus.app_rdy) begin
        cmd_t r;
        r.cyc = cyc; r.cmd = bus.app_cmd; r.addr = int'(bus.app_addr);
        cmd_q.push_back(r);
        if (bus.app_cmd == 3'b001) begin
          int due;
          due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          ret_q.push_back(due);
          last_due = due;
        end
      end
    end
  end

  // Controller responder: ready randomization and in-order read returns.
  initial forever begin
    @(posedge sclk); #1;
    if (rand_rdy) begin
      bus.app_rdy = ($urandom_range(0, 3) != 0);
      bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
    end
    if (!s_rst && ret_q.size() > 0 && ret_q[0] <= cyc) begin
      bus.app_rd_data_valid = 1'b1;
      void'(ret_q.pop_front());
    end else bus.app_rd_data_valid = 1'b0;
  end

  task automatic tick();
    @(posedge sclk); #2;
  endtask

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    while (cmd_q.size() < n && budget > 0) begin tick(); budget--; end
    ok = (cmd_q.size() >= n);
  endtask

  task automatic wait_rets(input int budget, output bit ok);
    while ((ret_q.size() > 0 || bus.app_rd_data_valid) && budget > 0) begin tick(); budget--; end
    ok = (ret_q.size() == 0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    ret_q.delete(); last_due = 0;
    repeat (2) tick();
    m_wr_beat = 0; m_rd_beat = 0; m_last_wr = 1;
    s_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({bus.app_en, bus.app_cmd, bus.app_addr, bus.app_wdf_wren, bus.app_wdf_end, bus.wfifo_rd_en,
         bus.rfifo_wr_en, bus.wr_frame_end, bus.rd_frame_end, bus.busy} !== '0) begin
      errors++; $display("FAIL reset_outputs app_en=%b cmd=%0d addr=%0d busy=%b want all 0",
                         bus.app_en, bus.app_cmd, bus.app_addr, bus.busy);
    end
    s_rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_calib_gate();
    int en0, b0, k;
    bit ok;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    bus.wr_trig = 1;
    en0 = en_n; b0 = busy_n;
    repeat (100) tick();
    checks++;
    if (en_n !== en0) begin errors++; $display("FAIL calib_gate_en got %0d want %0d", en_n - en0, 0); end
    checks++;
    if (busy_n !== b0) begin errors++; $display("FAIL calib_gate_busy got %0d want %0d", busy_n - b0, 0); end
    g_n0 = cmd_q.size(); g_wf0 = wfifo_n;
    bus.init_calib_complete = 1;
    k = cyc;
    wait_cmds(g_n0 + 1, 20, ok);
    bus.wr_trig = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL calib_first_cmd timeout got none want a write command");
    end else begin
      checks++;
      if (cmd_q[g_n0].cyc !== k + 2 || cmd_q[g_n0].addr !== 0 || cmd_q[g_n0].cmd !== 3'b000) begin
        errors++; $display("FAIL calib_first_cmd got cyc+%0d addr=%0d cmd=%0d want cyc+2 addr=0 cmd=0",
                           cmd_q[g_n0].cyc - k, cmd_q[g_n0].addr, cmd_q[g_n0].cmd);
      end
    end
    m_last_wr = 1;
  endtask

  task automatic test_write_burst();
    bit ok;
    wait_cmds(g_n0 + BL, 100, ok);
    repeat (5) tick();
    checks++;
    if (cmd_q.size() !== g_n0 + BL) begin
      errors++; $display("FAIL wr_burst_len got %0d want %0d", cmd_q.size() - g_n0, BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (cmd_q[g_n0+i].cmd !== 3'b000 || cmd_q[g_n0+i].addr !== m_wr_beat * STEP) begin
          errors++; $display("FAIL wr_burst_addr beat %0d got %0d want %0d", i, cmd_q[g_n0+i].addr, m_wr_beat * STEP);
        end
        m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++;
      end
      checks++;
      if (cmd_q[g_n0+BL-1].cyc - cmd_q[g_n0].cyc !== BL - 1) begin
        errors++; $display("FAIL wr_burst_span got %0d want %0d", cmd_q[g_n0+BL-1].cyc - cmd_q[g_n0].cyc, BL - 1);
      end
    end
    checks++;
    if (wfifo_n - g_wf0 !== BL) begin errors++; $display("FAIL wfifo_pops got %0d want %0d", wfifo_n - g_wf0, BL); end
  endtask

  task automatic test_wrap();
    int n0, wfe0, mwfe0;
    bit ok;
    n0 = cmd_q.size(); wfe0 = wfe_n; mwfe0 = m_wfe;
    bus.wr_trig = 1;
    wait_cmds(n0 + 1, 20, ok);
    bus.wr_trig = 0;
    wait_cmds(n0 + BL, 100, ok);
    repeat (5) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_burst timeout got %0d want %0d", cmd_q.size() - n0, BL); end
    else begin
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (cmd_q[n0+i].addr !== m_wr_beat * STEP) begin
          errors++; $display("FAIL wrap_addr beat %0d got %0d want %0d", i, cmd_q[n0+i].addr, m_wr_beat * STEP);
        end
        m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++;
      end
      checks++;
      if (wfe_n - wfe0 !== m_wfe - mwfe0) begin
        errors++; $display("FAIL wr_frame_end_count got %0d want %0d", wfe_n - wfe0, m_wfe - mwfe0);
      end
      checks++;
      if (wfe_cyc !== cmd_q[n0+BL-1].cyc + 1) begin
        errors++; $display("FAIL wr_frame_end_time got %0d want %0d", wfe_cyc, cmd_q[n0+BL-1].cyc + 1);
      end
    end
  endtask

  task automatic test_write_stall();
    int n0, wf0;
    bit ok;
    n0 = cmd_q.size(); wf0 = wfifo_n;
    bus.wr_trig = 1;
    wait_cmds(n0 + 1, 20, ok);
    bus.wr_trig = 0;
    wait_cmds(n0 + 3, 20, ok);
    bus.app_wdf_rdy = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if ({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wfifo_rd_en} !== 4'b0) begin
        errors++; $display("FAIL stall_outputs cycle %0d got %b want 0000", s,
                           {bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.wfifo_rd_en});
      end
      tick();
    end
    bus.app_wdf_rdy = 1;
    wait_cmds(n0 + BL, 100, ok);
    repeat (5) tick();
    checks++;
    if (cmd_q.size() !== n0 + BL || wfifo_n - wf0 !== BL) begin
      errors++; $display("FAIL stall_fires got %0d pops %0d want %0d", cmd_q.size() - n0, wfifo_n - wf0, BL);
    end else begin
      for (int i = 0; i < BL; i++) begin
        checks++;
        if (cmd_q[n0+i].addr !== m_wr_beat * STEP) begin
          errors++; $display("FAIL stall_addr beat %0d got %0d want %0d", i, cmd_q[n0+i].addr, m_wr_beat * STEP);
        end
        m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++;
      end
    end
  endtask

  task automatic test_read_burst();
    int n0, rf0;
    bit ok;
    lat = 20;
    n0 = cmd_q.size(); rf0 = rfifo_n;
    bus.rd_trig = 1;
    wait_cmds(n0 + 1, 20, ok);
    bus.rd_trig = 0;
    wait_cmds(n0 + BL, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_burst timeout got %0d want %0d", cmd_q.size() - n0, BL); return; end
    for (int i = 0; i < BL; i++) begin
      checks++;
      if (cmd_q[n0+i].cmd !== 3'b001 || cmd_q[n0+i].addr !== m_rd_beat * STEP) begin
        errors++; $display("FAIL rd_addr beat %0d got %0d want %0d", i, cmd_q[n0+i].addr, m_rd_beat * STEP);
      end
      m_rd_beat = (m_rd_beat + 1) % FB; if (m_rd_beat == 0) m_rfe++;
    end
    m_last_wr = 0;
    bus.wr_trig = 1;
    wait_cmds(n0 + BL + 1, 80, ok);
    bus.wr_trig = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_exit timeout got no write want one"); return; end
    checks++;
    if (rfifo_n - rf0 !== BL) begin errors++; $display("FAIL rfifo_pushes got %0d want %0d", rfifo_n - rf0, BL); end
    checks++;
    if (cmd_q[n0+BL].cyc !== last_ret_cyc + 2 || cmd_q[n0+BL].cmd !== 3'b000) begin
      errors++; $display("FAIL rd_exit_time got %0d want %0d", cmd_q[n0+BL].cyc, last_ret_cyc + 2);
    end
    wait_cmds(n0 + 2 * BL, 100, ok);
    repeat (5) tick();
    for (int i = 0; i < BL; i++) begin
      m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++;
    end
    m_last_wr = 1;
  endtask

  task automatic test_reset_mid_burst();
    int n0, n1;
    bit ok;
    lat = 20;
    n0 = cmd_q.size();
    bus.rd_trig = 1;
    wait_cmds(n0 + 5, 30, ok);
    bus.rd_trig = 0;
    s_rst = 1'b1;
    #1;
    checks++;
    if ({bus.app_en, bus.app_cmd, bus.app_addr, bus.app_wdf_wren, bus.app_wdf_end, bus.wfifo_rd_en,
         bus.rfifo_wr_en, bus.wr_frame_end, bus.rd_frame_end, bus.busy} !== '0) begin
      errors++; $display("FAIL midburst_reset_outputs app_en=%b cmd=%0d addr=%0d busy=%b want all 0",
                         bus.app_en, bus.app_cmd, bus.app_addr, bus.busy);
    end
    do_reset();
    n1 = cmd_q.size();
    bus.rd_trig = 1;
    wait_cmds(n1 + 1, 20, ok);
    bus.rd_trig = 0;
    checks++;
    if (!ok || cmd_q[n1].addr !== 0 || cmd_q[n1].cmd !== 3'b001) begin
      errors++; $display("FAIL rd_addr_after_reset got %0d want 0", ok ? cmd_q[n1].addr : -1);
    end
    wait_cmds(n1 + BL, 100, ok);
    wait_rets(200, ok);
    for (int i = 0; i < BL; i++) begin
      m_rd_beat = (m_rd_beat + 1) % FB; if (m_rd_beat == 0) m_rfe++;
    end
    m_last_wr = 0;
  endtask

  task automatic test_contention();
    int n0;
    bit ok;
    do_reset();
    rand_rdy = 1;
    lat = $urandom_range(5, 25);
    n0 = cmd_q.size();
    bus.wr_trig = 1; bus.rd_trig = 1;
    wait_cmds(n0 + 4 * BL, 2000, ok);
    bus.wr_trig = 0; bus.rd_trig = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL contention timeout got %0d want %0d", cmd_q.size() - n0, 4 * BL); end
    wait_rets(500, ok);
    checks++;
    if (cmd_q.size() !== n0 + 4 * BL) begin
      errors++; $display("FAIL contention_count got %0d want %0d", cmd_q.size() - n0, 4 * BL);
    end else begin
      for (int b = 0; b < 4; b++) begin
        logic [2:0] want = m_last_wr ? 3'b001 : 3'b000;
        for (int i = 0; i < BL; i++) begin
          int wa = (want == 3'b001) ? m_rd_beat * STEP : m_wr_beat * STEP;
          checks++;
          if (cmd_q[n0+b*BL+i].cmd !== want || cmd_q[n0+b*BL+i].addr !== wa) begin
            errors++; $display("FAIL contention burst %0d beat %0d got cmd %0d addr %0d want cmd %0d addr %0d",
                               b, i, cmd_q[n0+b*BL+i].cmd, cmd_q[n0+b*BL+i].addr, want, wa);
          end
          if (want == 3'b001) begin m_rd_beat = (m_rd_beat + 1) % FB; if (m_rd_beat == 0) m_rfe++; end
          else begin m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++; end
        end
        m_last_wr = (want == 3'b000);
      end
    end
  endtask

  task automatic test_random();
    int n0, wfe0, rfe0, mw0, mr0;
    bit ok, is_rd;
    wfe0 = wfe_n; rfe0 = rfe_n; mw0 = m_wfe; mr0 = m_rfe;
    rand_rdy = 1;
    for (int it = 0; it < 6; it++) begin
      is_rd = 1'($urandom_range(0, 1));
      lat = $urandom_range(2, 30);
      n0 = cmd_q.size();
      if (is_rd) bus.rd_trig = 1; else bus.wr_trig = 1;
      wait_cmds(n0 + 1, 200, ok);
      bus.rd_trig = 0; bus.wr_trig = 0;
      wait_cmds(n0 + BL, 400, ok);
      wait_rets(300, ok);
      checks++;
      if (cmd_q.size() !== n0 + BL) begin
        errors++; $display("FAIL random_len iter %0d got %0d want %0d", it, cmd_q.size() - n0, BL);
        continue;
      end
      for (int i = 0; i < BL; i++) begin
        int wa = is_rd ? m_rd_beat * STEP : m_wr_beat * STEP;
        checks++;
        if (cmd_q[n0+i].cmd !== {2'b00, is_rd} || cmd_q[n0+i].addr !== wa) begin
          errors++; $display("FAIL random iter %0d beat %0d got cmd %0d addr %0d want cmd %0d addr %0d",
                             it, i, cmd_q[n0+i].cmd, cmd_q[n0+i].addr, is_rd, wa);
        end
        if (is_rd) begin m_rd_beat = (m_rd_beat + 1) % FB; if (m_rd_beat == 0) m_rfe++; end
        else begin m_wr_beat = (m_wr_beat + 1) % FB; if (m_wr_beat == 0) m_wfe++; end
      end
    end
    rand_rdy = 0;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    checks++;
    if (wfe_n - wfe0 !== m_wfe - mw0 || rfe_n - rfe0 !== m_rfe - mr0) begin
      errors++; $display("FAIL random_frame_ends got wr %0d rd %0d want wr %0d rd %0d",
                         wfe_n - wfe0, rfe_n - rfe0, m_wfe - mw0, m_rfe - mr0);
    end
    checks++;
    if (bad_n !== 0) begin errors++; $display("FAIL handshake_rules got %0d violations want 0", bad_n); end
  endtask

  initial begin
    bus.init_calib_complete = 0; bus.wr_trig = 0; bus.rd_trig = 0;
    bus.app_rdy = 0; bus.app_wdf_rdy = 0; bus.app_rd_data_valid = 0;
    test_reset();
    test_calib_gate();
    test_write_burst();
    test_wrap();
    test_write_stall();
    test_read_burst();
    test_reset_mid_burst();
    test_contention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
